// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED pattern controller.
// Mode and run-state encodings, seed patterns and the delay range.
package led_ctrl_pkg;

    localparam int unsigned DELAY_W = 4;
    localparam logic [DELAY_W-1:0] DELAY_MAX = 4'd15;

    typedef enum logic [1:0] {
        SHIFT_L = 2'd0,
        SHIFT_R = 2'd1,
        BOUNCE  = 2'd2,
        COUNT   = 2'd3
    } mode_t;

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } run_state_t;

    localparam logic [3:0] SEED_SHIFT_L = 4'b0001;
    localparam logic [3:0] SEED_SHIFT_R = 4'b1000;
    localparam logic [3:0] SEED_BOUNCE  = 4'b0001;
    localparam logic [3:0] SEED_COUNT   = 4'b0000;

    function automatic logic [3:0] mode_seed(input mode_t m);
        logic [3:0] seed;
        case (m)
            SHIFT_L: seed = SEED_SHIFT_L;
            SHIFT_R: seed = SEED_SHIFT_R;
            BOUNCE:  seed = SEED_BOUNCE;
            default: seed = SEED_COUNT;
        endcase
        return seed;
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// Tick timer: a base counter of TICK_BASE cycles and a step counter of base
// periods; a tick fires on the base wrap where step has reached delay.
module tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_BASE = 3125000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clear,
    input  logic [DELAY_W-1:0] delay,
    output logic               tick
);

    localparam int unsigned BASE_W = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
    localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(TICK_BASE - 1);

    logic [BASE_W-1:0]  base_cnt;
    logic [DELAY_W-1:0] step_cnt;
    logic               base_wrap;
    logic               step_done;

    assign base_wrap = (base_cnt == BASE_LAST);
    // >= so that lowering delay below the current step ticks on the next wrap
    assign step_done = (step_cnt >= delay);
    assign tick      = enable && base_wrap && step_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_cnt <= '0;
            step_cnt <= '0;
        end else if (clear) begin
            base_cnt <= '0;
            step_cnt <= '0;
        end else if (enable) begin
            if (base_wrap) begin
                base_cnt <= '0;
                step_cnt <= step_done ? '0 : step_cnt + 4'd1;
            end else begin
                base_cnt <= base_cnt + BASE_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// 4-LED pattern sequencer driven by one-shot key commands: delay setting,
// run/pause, pattern mode and the pattern datapath around a tick timer.
//
//   state  | meaning
//   RUN    | timer counting, led advances on each tick
//   PAUSED | timer frozen, led held; delay and mode commands still accepted
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned        TICK_BASE  = 3125000,
    parameter logic [DELAY_W-1:0] DELAY_INIT = 4'd7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               faster,
    input  logic               slower,
    input  logic               next_mode,
    input  logic               pause,
    output logic [3:0]         led,
    output logic [DELAY_W-1:0] delay,
    output logic [1:0]         mode,
    output logic               running
);

    run_state_t         state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [3:0]         led_q, led_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               dir_up_q, dir_up_d;
    logic               tick;

    tick_gen #(
        .TICK_BASE(TICK_BASE)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (state_q == RUN),
        .clear  (next_mode),
        .delay  (delay_q),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            mode_q   <= SHIFT_L;
            led_q    <= SEED_SHIFT_L;
            delay_q  <= DELAY_INIT;
            dir_up_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            led_q    <= led_d;
            delay_q  <= delay_d;
            dir_up_q <= dir_up_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (pause) begin
            state_d = (state_q == RUN) ? PAUSED : RUN;
        end
    end

    always_comb begin
        delay_d = delay_q;
        if (faster && !slower && delay_q != '0) begin
            delay_d = delay_q - 4'd1;
        end else if (slower && !faster && delay_q != DELAY_MAX) begin
            delay_d = delay_q + 4'd1;
        end
    end

    // A mode change reseeds and swallows any tick landing in the same cycle.
    always_comb begin
        mode_d   = mode_q;
        led_d    = led_q;
        dir_up_d = dir_up_q;
        if (next_mode) begin
            mode_d   = mode_t'(mode_q + 2'd1);
            led_d    = mode_seed(mode_d);
            dir_up_d = 1'b1;
        end else if (tick) begin
            case (mode_q)
                SHIFT_L: led_d = {led_q[2:0], led_q[3]};
                SHIFT_R: led_d = {led_q[0], led_q[3:1]};
                BOUNCE: begin
                    if (dir_up_q) begin
                        if (led_q == 4'b1000) begin
                            led_d    = 4'b0100;
                            dir_up_d = 1'b0;
                        end else begin
                            led_d = {led_q[2:0], 1'b0};
                        end
                    end else begin
                        if (led_q == 4'b0001) begin
                            led_d    = 4'b0010;
                            dir_up_d = 1'b1;
                        end else begin
                            led_d = {1'b0, led_q[3:1]};
                        end
                    end
                end
                default: led_d = led_q + 4'd1;
            endcase
        end
    end

    assign led     = led_q;
    assign delay   = delay_q;
    assign mode    = mode_q;
    assign running = (state_q == RUN);

endmodule
